mem_write_buffer: RTL

Posted-write buffer between the cache controller's memory port and main memory. Cache writes complete after one cycle into a DEPTH-entry FIFO, which drains to memory in order. Cache reads take the youngest matching buffered entry, or go to memory ahead of any not-yet-started drain writes. This hides memory write latency from the cache without violating read-after-write ordering.

---
 rtl/mwb_pkg.sv | 18 +
 rtl/mwb_fifo.sv | 65 ++++++
 rtl/mem_write_buffer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mwb_pkg.sv
// Shared types for the posted-write buffer.
//   cache_state_t : cache-side handshake FSM states
//   mem_state_t   : memory-side drain/read FSM states
package mwb_pkg;

  typedef enum logic [1:0] {
    C_IDLE    = 2'd0,
    C_ACK     = 2'd1,
    C_RD_WAIT = 2'd2
  } cache_state_t;

  typedef enum logic [1:0] {
    M_IDLE  = 2'd0,
    M_WRITE = 2'd1,
    M_READ  = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mwb_fifo.sv
// Entry storage for the posted-write buffer.
// Ports:
//   clk, reset            clock, async active-low reset (pointers only)
//   push/push_addr/data   enqueue one entry at the clock edge
//   pop                   dequeue the head entry at the clock edge
//   empty, full           occupancy flags derived from the pointers
//   view_valid/addr/data  all slots flattened in age order: slot 0 is the
//                         head (oldest), slot count-1 the youngest
module mwb_fifo #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push,
  input  logic [ADDR_WIDTH-1:0]         push_addr,
  input  logic [DATA_WIDTH-1:0]         push_data,
  input  logic                          pop,
  output logic                          empty,
  output logic                          full,
  output logic [DEPTH-1:0]              view_valid,
  output logic [DEPTH*ADDR_WIDTH-1:0]   view_addr,
  output logic [DEPTH*DATA_WIDTH-1:0]   view_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PW:0]           wr_ptr, rd_ptr, count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + CW'(1);
      if (pop)  rd_ptr <= rd_ptr + CW'(1);
    end
  end

  // Contents need no reset: validity comes from the pointers alone.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr[PW-1:0]] <= push_addr;
      data_mem[wr_ptr[PW-1:0]] <= push_data;
    end
  end

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  // Rotate storage so the comparator sees entries oldest-first.
  for (genvar i = 0; i < DEPTH; i++) begin : g_view
    logic [PW-1:0] idx;
    assign idx = rd_ptr[PW-1:0] + PW'(i);
    assign view_valid[i] = (CW'(i) < count);
    assign view_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = addr_mem[idx];
    assign view_data[i*DATA_WIDTH +: DATA_WIDTH] = data_mem[idx];
  end

endmodule

// File: rtl/mem_write_buffer.sv
// Posted-write buffer between the cache memory port and main memory.
// Writes complete into a DEPTH-entry FIFO that drains in order; reads
// forward from the youngest matching entry or go to memory ahead of any
// not-yet-started drain write.
// Ports:
//   clk, reset                     clock, async active-low reset
//   cache_addr_in/data_in          cache request address / write data
//   cache_read_en/write_en         cache requests, held until cache_ready
//   cache_data_out, cache_ready    read data and one-cycle completion pulse
//   mem_addr_out/data_out          memory request address / write data
//   mem_read_en/write_en           memory requests, held until mem_ready
//   mem_data_in, mem_ready         memory read data and completion pulse
//   buf_empty, buf_full            buffer occupancy flags
//
// Cache FSM:
//   state     | meaning
//   C_IDLE    | accept a new read or write request
//   C_ACK     | cache_ready high; request inputs ignored
//   C_RD_WAIT | read miss posted, waiting for memory FSM
// Memory FSM:
//   state     | meaning
//   M_IDLE    | choose next transaction (pending read first)
//   M_WRITE   | draining head entry, waiting for mem_ready
//   M_READ    | read miss in flight, waiting for mem_ready
module mem_write_buffer
  import mwb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cache_addr_in,
  input  logic [DATA_WIDTH-1:0] cache_data_in,
  input  logic                  cache_read_en,
  input  logic                  cache_write_en,
  output logic [DATA_WIDTH-1:0] cache_data_out,
  output logic                  cache_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr_out,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  mem_read_en,
  output logic                  mem_write_en,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_ready,
  output logic                  buf_empty,
  output logic                  buf_full
);

  cache_state_t c_state, c_next;
  mem_state_t   m_state, m_next;

  logic                        fifo_empty, fifo_full;
  logic [DEPTH-1:0]            view_valid;
  logic [DEPTH*ADDR_WIDTH-1:0] view_addr;
  logic [DEPTH*DATA_WIDTH-1:0] view_data;

  logic                  push, pop, hit;
  logic [DATA_WIDTH-1:0] hit_data;
  logic                  wr_req, rd_lookup, rd_post, rd_pend, rd_want, rd_done;

  logic [DATA_WIDTH-1:0] cache_data_d, mem_data_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;

  mwb_fifo #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_addr  (cache_addr_in),
    .push_data  (cache_data_in),
    .pop        (pop),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .view_valid (view_valid),
    .view_addr  (view_addr),
    .view_data  (view_data)
  );

  // Slots are age-ordered, so the last match in the scan is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (view_valid[i] && (view_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == cache_addr_in)) begin
        hit      = 1'b1;
        hit_data = view_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A simultaneous write wins, so a read only looks up when write_en is low.
  assign wr_req    = (c_state == C_IDLE) && cache_write_en;
  assign rd_lookup = (c_state == C_IDLE) && cache_read_en && !cache_write_en;
  assign pop       = (m_state == M_WRITE) && mem_ready;
  assign push      = wr_req && (!fifo_full || pop);
  assign rd_post   = rd_lookup && !hit;
  assign rd_want   = rd_post || rd_pend;
  assign rd_done   = (m_state == M_READ) && mem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_state        <= C_IDLE;
      m_state        <= M_IDLE;
      rd_pend        <= 1'b0;
      cache_ready    <= 1'b0;
      cache_data_out <= '0;
      mem_addr_out   <= '0;
      mem_data_out   <= '0;
      mem_read_en    <= 1'b0;
      mem_write_en   <= 1'b0;
    end else begin
      c_state        <= c_next;
      m_state        <= m_next;
      // A miss posted while memory is busy waits here until M_IDLE takes it.
      rd_pend        <= (rd_pend || rd_post) && (m_state != M_IDLE);
      cache_ready    <= (c_next == C_ACK);
      cache_data_out <= cache_data_d;
      mem_addr_out   <= mem_addr_d;
      mem_data_out   <= mem_data_d;
      mem_read_en    <= (m_next == M_READ);
      mem_write_en   <= (m_next == M_WRITE);
    end
  end

  always_comb begin
    c_next = c_state;
    case (c_state)
      C_IDLE: begin
        if (cache_write_en) begin
          if (push) c_next = C_ACK;
        end else if (cache_read_en) begin
          c_next = hit ? C_ACK : C_RD_WAIT;
        end
      end
      C_ACK:     c_next = C_IDLE;
      C_RD_WAIT: if (rd_done) c_next = C_ACK;
      default:   c_next = C_IDLE;
    endcase
  end

  always_comb begin
    m_next = m_state;
    case (m_state)
      M_IDLE: begin
        if (rd_want)          m_next = M_READ;
        else if (!fifo_empty) m_next = M_WRITE;
      end
      M_WRITE: if (mem_ready) m_next = M_IDLE;
      M_READ:  if (mem_ready) m_next = M_IDLE;
      default: m_next = M_IDLE;
    endcase
  end

  always_comb begin
    cache_data_d = cache_data_out;
    if (rd_lookup && hit) cache_data_d = hit_data;
    else if (rd_done)     cache_data_d = mem_data_in;

    mem_addr_d = mem_addr_out;
    mem_data_d = mem_data_out;
    if (m_state == M_IDLE && m_next == M_READ) begin
      mem_addr_d = cache_addr_in;
      mem_data_d = '0;
    end else if (m_state == M_IDLE && m_next == M_WRITE) begin
      mem_addr_d = view_addr[ADDR_WIDTH-1:0];
      mem_data_d = view_data[DATA_WIDTH-1:0];
    end
  end

  assign buf_empty = fifo_empty;
  assign buf_full  = fifo_full;

endmodule
